fp_divsqrt_seq: RTL and testbench

- Issue sequencer upstream of the iterative fp_div / fp_sqrt units and fp_rnd.
- Accepts one divide or square-root request on a valid/ready handshake and latches the operands and rounding mode.
- Pulses the selected unit's start, waits for its done, captures the unrounded result (and divide-by-zero), and holds it for a valid/ready consumer feeding fp_rnd.
- One operation in flight at a time.

---
 rtl/fp_divsqrt_seq_pkg.sv | 58 +++++
 rtl/fp_divsqrt_seq.sv | 151 +++++++++++++++
 tb/tb_fp_divsqrt_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_divsqrt_seq_pkg.sv
// Shared types for the divide/sqrt issue sequencer: formats, rounding modes,
// unrounded result bundle and the sequencer's op/state encodings.
package fp_divsqrt_seq_pkg;

  typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

  localparam int FP_MAX_W  = 64;
  localparam int SEQ_LAT_W = 16;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  // Pre-rounding result: packed value plus guard/sticky for fp_rnd.
  typedef struct packed {
    logic [FP_MAX_W-1:0] val;
    logic                guard;
    logic                sticky;
    fp_flags_t           flags;
  } uround_res_t;

  typedef enum logic {OP_DIV, OP_SQRT} divsqrt_op_e;

  typedef enum logic [1:0] {IDLE, START, BUSY, HOLD} seq_state_e;

  function automatic int fp_width(fp_format_e f);
    case (f)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

  function automatic uround_res_t fp_qnan_res(fp_format_e f);
    uround_res_t r;
    r = '0;
    case (f)
      FP16:    r.val = 64'h0000_0000_0000_7E00;
      FP64:    r.val = 64'h7FF8_0000_0000_0000;
      default: r.val = 64'h0000_0000_7FC0_0000;
    endcase
    r.flags.nv = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_divsqrt_seq.sv
// Issue sequencer for the iterative fp_div / fp_sqrt units; one op in flight.
// Optional BUSY watchdog enabled by defining FP_SEQ_WDOG_EN.
module fp_divsqrt_seq
  import fp_divsqrt_seq_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  parameter int         TAG_W     = 4,
  parameter int         TIMEOUT   = 255,
  localparam int        FP_WIDTH  = fp_width(FP_FORMAT)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 kill_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 op_i,
  input  logic [FP_WIDTH-1:0]  a_i,
  input  logic [FP_WIDTH-1:0]  b_i,
  input  roundmode_e           rnd_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic [FP_WIDTH-1:0]  a_o,
  output logic [FP_WIDTH-1:0]  b_o,
  output logic                 div_start_o,
  output logic                 sqrt_start_o,
  input  logic                 div_done_i,
  input  logic                 sqrt_done_i,
  input  uround_res_t          div_urnd_i,
  input  uround_res_t          sqrt_urnd_i,
  input  logic                 div_dz_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output uround_res_t          urnd_result_o,
  output roundmode_e           rnd_o,
  output logic                 dz_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [SEQ_LAT_W-1:0] lat_o,
  output logic                 timeout_o
);

`ifdef FP_SEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam logic [SEQ_LAT_W-1:0] TIMEOUT_CNT = SEQ_LAT_W'(TIMEOUT);

  seq_state_e           state_q;
  divsqrt_op_e          op_q;
  logic [FP_WIDTH-1:0]  a_q, b_q;
  roundmode_e           rnd_q;
  logic [TAG_W-1:0]     tag_q;
  logic [SEQ_LAT_W-1:0] cnt_q, cnt_d, lat_q;
  uround_res_t          res_q;
  logic                 dz_q;
  logic                 in_ready_q, out_valid_q;
  logic                 div_start_q, sqrt_start_q, timeout_q;
  logic                 sel_done, wdog_hit;

  // Counter saturates so a stuck unit cannot wrap the latency report.
  assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign sel_done = (op_q == OP_SQRT) ? sqrt_done_i : div_done_i;
  assign wdog_hit = WDOG_EN && (cnt_d == TIMEOUT_CNT);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      op_q         <= OP_DIV;
      a_q          <= '0;
      b_q          <= '0;
      rnd_q        <= RNE;
      tag_q        <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
      res_q        <= '0;
      dz_q         <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      div_start_q  <= 1'b0;
      sqrt_start_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      div_start_q  <= 1'b0;
      sqrt_start_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (kill_i) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            in_ready_q <= 1'b1;
            if (in_valid_i && in_ready_q) begin
              op_q         <= divsqrt_op_e'(op_i);
              a_q          <= a_i;
              b_q          <= b_i;
              rnd_q        <= rnd_i;
              tag_q        <= tag_i;
              cnt_q        <= '0;
              in_ready_q   <= 1'b0;
              div_start_q  <= (op_i == 1'b0);
              sqrt_start_q <= (op_i == 1'b1);
              state_q      <= START;
            end
          end
          START: state_q <= BUSY;
          BUSY: begin
            cnt_q <= cnt_d;
            if (sel_done) begin
              res_q       <= (op_q == OP_SQRT) ? sqrt_urnd_i : div_urnd_i;
              dz_q        <= div_dz_i && (op_q == OP_DIV);
              lat_q       <= cnt_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else if (wdog_hit) begin
              res_q       <= fp_qnan_res(FP_FORMAT);
              dz_q        <= 1'b0;
              lat_q       <= TIMEOUT_CNT;
              timeout_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
          HOLD: begin
            if (out_ready_i) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready_o    = in_ready_q;
  assign a_o           = a_q;
  assign b_o           = b_q;
  assign div_start_o   = div_start_q;
  assign sqrt_start_o  = sqrt_start_q;
  assign out_valid_o   = out_valid_q;
  assign urnd_result_o = res_q;
  assign rnd_o         = rnd_q;
  assign dz_o          = dz_q;
  assign tag_o         = tag_q;
  assign lat_o         = lat_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_fp_divsqrt_seq.sv
// Scoreboard bench for fp_divsqrt_seq with inline div/sqrt unit stubs.
// Define FP_SEQ_WDOG_EN to also exercise the watchdog path.
module tb_fp_divsqrt_seq;
  import fp_divsqrt_seq_pkg::*;

`ifdef FP_SEQ_WDOG_EN
  localparam bit TB_WDOG    = 1'b1;
  localparam int TB_TIMEOUT = 8;
`else
  localparam bit TB_WDOG    = 1'b0;
  localparam int TB_TIMEOUT = 255;
`endif
  localparam int SQRT_LAT = TB_WDOG ? 7 : 25;
  localparam int DZ_LAT   = TB_WDOG ? 5 : 10;

  typedef struct {
    logic [63:0] val;
    logic [4:0]  flags;
    logic        dz;
    logic [15:0] lat;
    logic [3:0]  tag;
    logic [2:0]  rnd;
  } exp_t;

  exp_t sbQueue[$];
  int checks = 0;
  int failures = 0;
  int timeoutPulses = 0;

  logic        clk = 1'b0;
  logic        resetN, kill, inValid, inReady, op;
  logic [31:0] aIn, bIn, aOut, bOut;
  roundmode_e  rndIn, rndOut;
  logic [3:0]  tagIn, tagOut;
  logic        divStart, sqrtStart, divDone, sqrtDone, divDz;
  uround_res_t divUrnd, sqrtUrnd, urndResult;
  logic        outValid, outReady, dzOut, timeoutOut;
  logic [15:0] latOut;

  fp_divsqrt_seq #(.FP_FORMAT(FP32), .TAG_W(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i(clk), .reset_i(resetN), .kill_i(kill),
    .in_valid_i(inValid), .in_ready_o(inReady), .op_i(op),
    .a_i(aIn), .b_i(bIn), .rnd_i(rndIn), .tag_i(tagIn),
    .a_o(aOut), .b_o(bOut), .div_start_o(divStart), .sqrt_start_o(sqrtStart),
    .div_done_i(divDone), .sqrt_done_i(sqrtDone),
    .div_urnd_i(divUrnd), .sqrt_urnd_i(sqrtUrnd), .div_dz_i(divDz),
    .out_valid_o(outValid), .out_ready_i(outReady),
    .urnd_result_o(urndResult), .rnd_o(rndOut), .dz_o(dzOut),
    .tag_o(tagOut), .lat_o(latOut), .timeout_o(timeoutOut)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (timeoutOut) timeoutPulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic opIn, input logic [31:0] a, input logic [31:0] b,
                               input roundmode_e rnd, input logic [3:0] tag);
    int waitCycles = 0;
    while (!inReady && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkOutput("inReadyWait", inReady, 1);
    inValid = 1'b1; op = opIn; aIn = a; bIn = b; rndIn = rnd; tagIn = tag;
    tick();
    // Scramble request inputs so later checks prove the values were latched.
    inValid = 1'b0; aIn = 32'hA5A5_A5A5; bIn = 32'h5A5A_5A5A; rndIn = RMM; tagIn = ~tag;
  endtask

  // doneAt: BUSY cycle in which the selected unit signals done (0 = never).
  task automatic runOp(input logic opIn, input logic [31:0] a, input logic [31:0] b,
                       input roundmode_e rnd, input logic [3:0] tag, input int doneAt,
                       input logic dzIn, input logic [63:0] resVal, input logic [4:0] resFlags,
                       input int bpCycles, input bit spurious);
    exp_t        e;
    uround_res_t stub, junk, snapRes;
    logic [3:0]  snapTag;
    int          busy;
    bit          gotValid;
    stub = '0; stub.val = resVal; stub.flags = resFlags; stub.guard = 1'b1;
    junk = '0; junk.val = 64'hDEAD_BEEF; junk.flags = 5'b00001;
    if (doneAt == 0) begin
      e.val = 64'h7FC0_0000; e.flags = 5'b10000; e.dz = 1'b0; e.lat = 16'(TB_TIMEOUT);
    end else begin
      e.val = resVal; e.flags = resFlags; e.dz = dzIn && (opIn == 1'b0); e.lat = 16'(doneAt);
    end
    e.tag = tag; e.rnd = rnd;
    applyStimulus(opIn, a, b, rnd, tag);
    sbQueue.push_back(e);

    checkOutput("divStart", divStart, opIn == 1'b0);
    checkOutput("sqrtStart", sqrtStart, opIn == 1'b1);
    checkOutput("aHeld", aOut, a);
    if (opIn == 1'b0) checkOutput("bHeld", bOut, b);
    checkOutput("rndHeld", rndOut, rnd);
    if (spurious) begin
      if (opIn) begin sqrtDone = 1'b1; sqrtUrnd = junk; end
      else begin divDone = 1'b1; divUrnd = junk; end
    end

    busy = 0; gotValid = 0;
    while (!gotValid && busy < 60) begin
      tick();
      divDone = 1'b0; sqrtDone = 1'b0; divDz = 1'b0;
      if (outValid) gotValid = 1;
      else begin
        busy++;
        checkOutput("noExtraStart", {divStart, sqrtStart}, 0);
        checkOutput("inReadyBusy", inReady, 0);
        if (busy == doneAt) begin
          if (opIn) begin sqrtDone = 1'b1; sqrtUrnd = stub; end
          else begin divDone = 1'b1; divUrnd = stub; end
          divDz = dzIn;
        end
        if (spurious && busy == 2) begin
          if (opIn) begin divDone = 1'b1; divUrnd = junk; end
          else begin sqrtDone = 1'b1; sqrtUrnd = junk; end
        end
      end
    end
    checkOutput("validSeen", gotValid, 1);
    checkOutput("busyCycles", busy, (doneAt == 0) ? TB_TIMEOUT : doneAt);
    checkOutput("timeoutPulse", timeoutOut, doneAt == 0);

    snapRes = urndResult; snapTag = tagOut;
    outReady = 1'b0;
    for (int i = 0; i < bpCycles; i++) begin
      checkOutput("bpValid", outValid, 1);
      checkOutput("bpInReady", inReady, 0);
      checkOutput("bpResStable", urndResult.val, snapRes.val);
      checkOutput("bpTagStable", tagOut, snapTag);
      tick();
    end
    outReady = 1'b1;
    if (sbQueue.size() == 0) checkOutput("sbUnderflow", 1, 0);
    else begin
      e = sbQueue.pop_front();
      checkOutput("resVal", urndResult.val, e.val);
      checkOutput("resFlags", urndResult.flags, e.flags);
      checkOutput("dz", dzOut, e.dz);
      checkOutput("lat", latOut, e.lat);
      checkOutput("tag", tagOut, e.tag);
      checkOutput("rnd", rndOut, e.rnd);
    end
    checkOutput("holdValid", outValid, 1);
    checkOutput("holdInReady", inReady, 0);
    tick();
    outReady = 1'b0;
    checkOutput("dropValid", outValid, 0);
    checkOutput("idleInReady", inReady, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout got=running exp=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    resetN = 1'b0; kill = 1'b0; inValid = 1'b0; op = 1'b0;
    aIn = '0; bIn = '0; rndIn = RNE; tagIn = '0;
    divDone = 1'b0; sqrtDone = 1'b0; divDz = 1'b0;
    divUrnd = '0; sqrtUrnd = '0; outReady = 1'b0;
    tick(); tick();
    checkOutput("rstInReady", inReady, 0);
    checkOutput("rstValid", outValid, 0);
    checkOutput("rstStarts", {divStart, sqrtStart}, 0);
    checkOutput("rstRnd", rndOut, RNE);
    checkOutput("rstLat", latOut, 0);
    checkOutput("rstUrnd", urndResult.val, 0);
    checkOutput("rstTimeout", timeoutOut, 0);
    resetN = 1'b1;
    tick();
    checkOutput("postRstInReady", inReady, 1);

    $display("[TB] sqrt with known stub result");
    runOp(1'b1, 32'h4080_0000, 32'h0, RTZ, 4'h5, SQRT_LAT, 1'b0, 64'h4000_0000, 5'b00000, 0, 1'b0);
    $display("[TB] divide by zero");
    runOp(1'b0, 32'h3F80_0000, 32'h0, RUP, 4'h9, DZ_LAT, 1'b1, 64'h7F80_0000, 5'b01000, 0, 1'b0);
    $display("[TB] backpressure in HOLD");
    runOp(1'b0, 32'h4040_0000, 32'h4000_0000, RDN, 4'h3, 4, 1'b0, 64'h3FC0_0000, 5'b00001, 7, 1'b0);
    $display("[TB] spurious dones during sqrt");
    runOp(1'b1, 32'h41C8_0000, 32'h0, RMM, 4'hC, 6, 1'b1, 64'h40A0_0000, 5'b00000, 2, 1'b1);

    $display("[TB] kill in BUSY");
    applyStimulus(1'b0, 32'h4000_0000, 32'h3F80_0000, RMM, 4'hA);
    checkOutput("killStart", divStart, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      divDone = 1'b0; kill = 1'b0;
      if (k == 5) kill = 1'b1;
      if (k == 6) begin
        checkOutput("killIdle", inReady, 1);
        checkOutput("killNoValid", outValid, 0);
      end
      if (k == 9) begin divDone = 1'b1; divUrnd = '1; end
      if (k > 6) begin
        checkOutput("lateDoneValid", outValid, 0);
        checkOutput("lateDoneStart", {divStart, sqrtStart}, 0);
      end
    end

    $display("[TB] kill coinciding with accept");
    inValid = 1'b1; kill = 1'b1; op = 1'b1; aIn = 32'h4110_0000;
    tick();
    inValid = 1'b0; kill = 1'b0;
    checkOutput("killAccStart", {divStart, sqrtStart}, 0);
    checkOutput("killAccReady", inReady, 1);
    tick();
    checkOutput("killAccStart2", {divStart, sqrtStart}, 0);

`ifdef FP_SEQ_WDOG_EN
    $display("[TB] watchdog expiry");
    runOp(1'b1, 32'hBF80_0000, 32'h0, RNE, 4'hE, 0, 1'b0, 64'h0, 5'b00000, 1, 1'b0);
`endif

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'h4110_0000, 32'h0, RDN, 4'h7);
    tick(); tick();
    resetN = 1'b0;
    #1;
    checkOutput("midRstValid", outValid, 0);
    checkOutput("midRstReady", inReady, 0);
    checkOutput("midRstLat", latOut, 0);
    checkOutput("midRstRnd", rndOut, RNE);
    checkOutput("midRstTag", tagOut, 0);
    checkOutput("midRstA", aOut, 0);
    tick();
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("postRstStart", {divStart, sqrtStart}, 0);
      checkOutput("postRstValid", outValid, 0);
    end
    checkOutput("postRstIdle", inReady, 1);

    checkOutput("sbEmpty", sbQueue.size(), 0);
    checkOutput("timeoutCount", timeoutPulses, TB_WDOG ? 1 : 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
